// File: rtl/scr1_mem_arb_pkg.sv
// Shared memif types for the SCR1 memory arbiter: command, width, response
// and requester ID enums, plus a small response helper.
package scr1_mem_arb_pkg;

    typedef enum logic {
        SCR1_MEM_CMD_RD = 1'b0,
        SCR1_MEM_CMD_WR = 1'b1
    } type_scr1_mem_cmd_e;

    typedef enum logic [1:0] {
        SCR1_MEM_WIDTH_BYTE  = 2'b00,
        SCR1_MEM_WIDTH_HWORD = 2'b01,
        SCR1_MEM_WIDTH_WORD  = 2'b10,
        SCR1_MEM_WIDTH_ERROR = 2'b11
    } type_scr1_mem_width_e;

    typedef enum logic [1:0] {
        SCR1_MEM_RESP_NOTRDY = 2'b00,
        SCR1_MEM_RESP_RDY_OK = 2'b01,
        SCR1_MEM_RESP_RDY_ER = 2'b10
    } type_scr1_mem_resp_e;

    typedef enum logic {
        SCR1_ARB_IMEM = 1'b0,
        SCR1_ARB_DMEM = 1'b1
    } type_scr1_arb_id_e;

    // Both OK and ER complete a transaction.
    function automatic logic scr1_resp_done(input type_scr1_mem_resp_e resp);
        return (resp != SCR1_MEM_RESP_NOTRDY);
    endfunction

endpackage

// File: rtl/scr1_arb_id_fifo.sv
// Owner-ID FIFO for scr1_mem_arb: one bit per outstanding downstream
// transaction, kept in acceptance order so responses return to their owner.
module scr1_arb_id_fifo
    import scr1_mem_arb_pkg::*;
#(
    parameter int unsigned DEPTH = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              push,
    input  type_scr1_arb_id_e push_id,
    input  logic              pop,
    output type_scr1_arb_id_e head_id,
    output logic              full,
    output logic              empty
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);
    localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(DEPTH - 1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);

    type_scr1_arb_id_e ids_q [DEPTH];
    type_scr1_arb_id_e ids_d [DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_LAST) ? PTR_W'(0) : p + PTR_W'(1);
    endfunction

    // Next-state for storage, pointers and occupancy.
    always_comb begin
        ids_d    = ids_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (push) begin
            ids_d[wr_ptr_q] = push_id;
            wr_ptr_d        = ptr_inc(wr_ptr_q);
        end else begin
            wr_ptr_d = wr_ptr_q;
        end
        if (pop) begin
            rd_ptr_d = ptr_inc(rd_ptr_q);
        end else begin
            rd_ptr_d = rd_ptr_q;
        end
        case ({push, pop})
            2'b10:   cnt_d = cnt_q + CNT_W'(1);
            2'b01:   cnt_d = cnt_q - CNT_W'(1);
            default: cnt_d = cnt_q;
        endcase
    end

    // State registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                ids_q[i] <= SCR1_ARB_IMEM;
            end
            wr_ptr_q <= PTR_W'(0);
            rd_ptr_q <= PTR_W'(0);
            cnt_q    <= CNT_W'(0);
        end else begin
            ids_q    <= ids_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

    assign head_id = ids_q[rd_ptr_q];
    assign full    = (cnt_q == CNT_FULL);
    assign empty   = (cnt_q == CNT_W'(0));

endmodule

// File: rtl/scr1_mem_arb_sva.sv
// Protocol checkers for scr1_mem_arb, compiled only in simulation builds
// that define SCR1_SYN_OFF_EN.
`ifdef SCR1_SYN_OFF_EN
module scr1_mem_arb_sva
    import scr1_mem_arb_pkg::*;
(
    input logic                clk,
    input logic                rst,
    input logic                imem_req,
    input logic                dmem_req,
    input type_scr1_mem_resp_e mem_resp,
    input logic                mem_req,
    input logic                full,
    input logic                empty
);

    a_req_known:  assert property (@(posedge clk) disable iff (rst) !$isunknown({imem_req, dmem_req}));
    a_resp_known: assert property (@(posedge clk) disable iff (rst) !$isunknown(mem_resp));
    a_resp_empty: assert property (@(posedge clk) disable iff (rst) !(scr1_resp_done(mem_resp) && empty));
    a_req_full:   assert property (@(posedge clk) disable iff (rst) !(mem_req && full));

endmodule
`endif

// File: rtl/scr1_mem_arb.sv
// Two-requester memif arbiter (imem/dmem) onto one downstream memif with
// round-robin conflict resolution and in-order response routing.
module scr1_mem_arb
    import scr1_mem_arb_pkg::*;
#(
    parameter int unsigned SCR1_ARB_DEPTH = 2,
    parameter int unsigned SCR1_ARB_AW    = 32
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    imem_req,
    output logic                    imem_req_ack,
    input  logic [SCR1_ARB_AW-1:0]  imem_addr,
    output logic [SCR1_ARB_AW-1:0]  imem_rdata,
    output type_scr1_mem_resp_e     imem_resp,
    input  logic                    dmem_req,
    output logic                    dmem_req_ack,
    input  type_scr1_mem_cmd_e      dmem_cmd,
    input  type_scr1_mem_width_e    dmem_width,
    input  logic [SCR1_ARB_AW-1:0]  dmem_addr,
    input  logic [SCR1_ARB_AW-1:0]  dmem_wdata,
    output logic [SCR1_ARB_AW-1:0]  dmem_rdata,
    output type_scr1_mem_resp_e     dmem_resp,
    output logic                    mem_req,
    input  logic                    mem_req_ack,
    output type_scr1_mem_cmd_e      mem_cmd,
    output type_scr1_mem_width_e    mem_width,
    output logic [SCR1_ARB_AW-1:0]  mem_addr,
    output logic [SCR1_ARB_AW-1:0]  mem_wdata,
    input  logic [SCR1_ARB_AW-1:0]  mem_rdata,
    input  type_scr1_mem_resp_e     mem_resp
);

    type_scr1_arb_id_e last_grant_q, last_grant_d;
    type_scr1_arb_id_e sel;
    type_scr1_arb_id_e head_id;
    logic              full, empty;
    logic              handshake, resp_pop;

    // Grant selection: sole requester wins, otherwise whoever was not granted last.
    always_comb begin
        sel = SCR1_ARB_IMEM;
        if (imem_req && !dmem_req) begin
            sel = SCR1_ARB_IMEM;
        end else if (dmem_req && !imem_req) begin
            sel = SCR1_ARB_DMEM;
        end else if (last_grant_q == SCR1_ARB_IMEM) begin
            sel = SCR1_ARB_DMEM;
        end else begin
            sel = SCR1_ARB_IMEM;
        end
    end

    // Request-path mux; imem is always a word read, wdata only matters for dmem.
    always_comb begin
        mem_wdata = dmem_wdata;
        case (sel)
            SCR1_ARB_DMEM: begin
                mem_req   = dmem_req & ~full;
                mem_cmd   = dmem_cmd;
                mem_width = dmem_width;
                mem_addr  = dmem_addr;
            end
            default: begin
                mem_req   = imem_req & ~full;
                mem_cmd   = SCR1_MEM_CMD_RD;
                mem_width = SCR1_MEM_WIDTH_WORD;
                mem_addr  = imem_addr;
            end
        endcase
        imem_req_ack = (sel == SCR1_ARB_IMEM) & mem_req_ack & ~full;
        dmem_req_ack = (sel == SCR1_ARB_DMEM) & mem_req_ack & ~full;
        handshake    = mem_req & mem_req_ack & ~full;
        last_grant_d = handshake ? sel : last_grant_q;
    end

    // Response path: a completed response goes to the FIFO head owner only.
    always_comb begin
        resp_pop   = scr1_resp_done(mem_resp) & ~empty;
        imem_rdata = mem_rdata;
        dmem_rdata = mem_rdata;
        if (resp_pop && (head_id == SCR1_ARB_IMEM)) begin
            imem_resp = mem_resp;
            dmem_resp = SCR1_MEM_RESP_NOTRDY;
        end else if (resp_pop) begin
            imem_resp = SCR1_MEM_RESP_NOTRDY;
            dmem_resp = mem_resp;
        end else begin
            imem_resp = SCR1_MEM_RESP_NOTRDY;
            dmem_resp = SCR1_MEM_RESP_NOTRDY;
        end
    end

    // Last-grant register; reset to imem so dmem wins the first conflict.
    always_ff @(posedge clk) begin
        if (rst) begin
            last_grant_q <= SCR1_ARB_IMEM;
        end else begin
            last_grant_q <= last_grant_d;
        end
    end

    scr1_arb_id_fifo #(
        .DEPTH (SCR1_ARB_DEPTH)
    ) u_id_fifo (
        .clk     (clk),
        .rst     (rst),
        .push    (handshake),
        .push_id (sel),
        .pop     (resp_pop),
        .head_id (head_id),
        .full    (full),
        .empty   (empty)
    );

`ifdef SCR1_SYN_OFF_EN
    scr1_mem_arb_sva u_sva (
        .clk      (clk),
        .rst      (rst),
        .imem_req (imem_req),
        .dmem_req (dmem_req),
        .mem_resp (mem_resp),
        .mem_req  (mem_req),
        .full     (full),
        .empty    (empty)
    );
`endif

endmodule

// File: tb/tb_scr1_mem_arb.sv
// Self-checking bench for scr1_mem_arb: directed scenarios plus randomized
// traffic, all checked against a queue-based reference model.
module tb_scr1_mem_arb;
    import scr1_mem_arb_pkg::*;

    localparam int unsigned DEPTH = 2;
    localparam int unsigned AW    = 32;

    logic clk = 1'b0;
    logic rst;
    logic imem_req, imem_req_ack;
    logic [AW-1:0] imem_addr, imem_rdata;
    type_scr1_mem_resp_e imem_resp;
    logic dmem_req, dmem_req_ack;
    type_scr1_mem_cmd_e dmem_cmd;
    type_scr1_mem_width_e dmem_width;
    logic [AW-1:0] dmem_addr, dmem_wdata, dmem_rdata;
    type_scr1_mem_resp_e dmem_resp;
    logic mem_req, mem_req_ack;
    type_scr1_mem_cmd_e mem_cmd;
    type_scr1_mem_width_e mem_width;
    logic [AW-1:0] mem_addr, mem_wdata, mem_rdata;
    type_scr1_mem_resp_e mem_resp;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: queue of owners (0=imem, 1=dmem) and last grant.
    bit mq[$];
    bit m_lg;
    bit e_sel, e_mem_req, e_iack, e_dack, e_hs, e_pop;
    type_scr1_mem_resp_e e_iresp, e_dresp;

    always #5 clk = ~clk;

    scr1_mem_arb #(.SCR1_ARB_DEPTH(DEPTH), .SCR1_ARB_AW(AW)) dut (
        .clk(clk), .rst(rst),
        .imem_req(imem_req), .imem_req_ack(imem_req_ack), .imem_addr(imem_addr),
        .imem_rdata(imem_rdata), .imem_resp(imem_resp),
        .dmem_req(dmem_req), .dmem_req_ack(dmem_req_ack), .dmem_cmd(dmem_cmd),
        .dmem_width(dmem_width), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
        .dmem_rdata(dmem_rdata), .dmem_resp(dmem_resp),
        .mem_req(mem_req), .mem_req_ack(mem_req_ack), .mem_cmd(mem_cmd),
        .mem_width(mem_width), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_resp(mem_resp)
    );

    task automatic model_eval();
        bit is_full;
        is_full = (mq.size() == DEPTH);
        if (imem_req && !dmem_req)      e_sel = 1'b0;
        else if (dmem_req && !imem_req) e_sel = 1'b1;
        else                            e_sel = !m_lg;
        e_mem_req = !is_full && (e_sel ? dmem_req : imem_req);
        e_iack    = !is_full && !e_sel && mem_req_ack;
        e_dack    = !is_full &&  e_sel && mem_req_ack;
        e_hs      = e_mem_req && mem_req_ack;
        e_pop     = (mem_resp != SCR1_MEM_RESP_NOTRDY) && (mq.size() > 0);
        e_iresp   = SCR1_MEM_RESP_NOTRDY;
        e_dresp   = SCR1_MEM_RESP_NOTRDY;
        if (e_pop && mq[0] == 1'b0) e_iresp = mem_resp;
        if (e_pop && mq[0] == 1'b1) e_dresp = mem_resp;
    endtask

    task automatic tick();
        model_eval();
        @(posedge clk);
        if (rst) begin
            mq.delete();
            m_lg = 1'b0;
        end else begin
            if (e_pop) void'(mq.pop_front());
            if (e_hs) begin
                mq.push_back(e_sel);
                m_lg = e_sel;
            end
        end
        @(negedge clk);
    endtask

    task automatic idle_inputs();
        imem_req = 1'b0; dmem_req = 1'b0; mem_req_ack = 1'b0;
        imem_addr = 32'h0; dmem_addr = 32'h0; dmem_wdata = 32'h0;
        dmem_cmd = SCR1_MEM_CMD_RD; dmem_width = SCR1_MEM_WIDTH_WORD;
        mem_rdata = 32'h0; mem_resp = SCR1_MEM_RESP_NOTRDY;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        idle_inputs();
        rst = 1'b1;
        tick();
        tick();
        imem_req = 1'b1; mem_req_ack = 1'b1; mem_resp = SCR1_MEM_RESP_RDY_OK;
        #1;
        n_checks++;
        if (imem_req_ack !== 1'b1 || dmem_req_ack !== 1'b0) begin
            n_fail++; $display("FAIL reset_acks got i=%b d=%b exp i=1 d=0", imem_req_ack, dmem_req_ack);
        end
        n_checks++;
        if (imem_resp !== SCR1_MEM_RESP_NOTRDY || dmem_resp !== SCR1_MEM_RESP_NOTRDY) begin
            n_fail++; $display("FAIL reset_resp got i=%0d d=%0d exp 0/0", imem_resp, dmem_resp);
        end
        tick();
        rst = 1'b0;
        idle_inputs();
    endtask

    task automatic test_single_imem();
        do_reset();
        imem_req = 1'b1; imem_addr = 32'h200; mem_req_ack = 1'b1;
        #1;
        n_checks++;
        if (mem_req !== 1'b1 || mem_addr !== 32'h200 || imem_req_ack !== 1'b1) begin
            n_fail++; $display("FAIL single_req got req=%b addr=%h ack=%b exp 1/200/1", mem_req, mem_addr, imem_req_ack);
        end
        n_checks++;
        if (mem_cmd !== SCR1_MEM_CMD_RD || mem_width !== SCR1_MEM_WIDTH_WORD) begin
            n_fail++; $display("FAIL single_cmd got cmd=%0d width=%0d exp 0/2", mem_cmd, mem_width);
        end
        tick();
        imem_req = 1'b0; mem_req_ack = 1'b0; mem_resp = SCR1_MEM_RESP_RDY_OK; mem_rdata = 32'h13;
        #1;
        n_checks++;
        if (imem_resp !== SCR1_MEM_RESP_RDY_OK || imem_rdata !== 32'h13 || dmem_resp !== SCR1_MEM_RESP_NOTRDY) begin
            n_fail++; $display("FAIL single_resp got i=%0d rd=%h d=%0d exp 1/13/0", imem_resp, imem_rdata, dmem_resp);
        end
        tick();
        idle_inputs();
    endtask

    task automatic test_conflict();
        do_reset();
        imem_req = 1'b1; dmem_req = 1'b1; mem_req_ack = 1'b1;
        imem_addr = 32'h400; dmem_addr = 32'h800;
        for (int k = 0; k < 6; k++) begin
            mem_resp = (k == 0) ? SCR1_MEM_RESP_NOTRDY : SCR1_MEM_RESP_RDY_OK;
            #1;
            n_checks++;
            if (dmem_req_ack !== ((k % 2) == 0) || imem_req_ack !== ((k % 2) == 1)) begin
                n_fail++; $display("FAIL conflict_grant cyc=%0d got i=%b d=%b exp d=%b", k, imem_req_ack, dmem_req_ack, (k % 2) == 0);
            end
            if (k == 1) begin
                n_checks++;
                if (dmem_resp !== SCR1_MEM_RESP_RDY_OK || imem_resp !== SCR1_MEM_RESP_NOTRDY) begin
                    n_fail++; $display("FAIL conflict_resp got i=%0d d=%0d exp 0/1", imem_resp, dmem_resp);
                end
            end
            tick();
        end
        idle_inputs();
    endtask

    task automatic test_back_to_back();
        do_reset();
        imem_req = 1'b1; mem_req_ack = 1'b1;
        for (int k = 0; k < int'(DEPTH); k++) begin
            #1;
            n_checks++;
            if (imem_req_ack !== 1'b1) begin
                n_fail++; $display("FAIL fill_accept cyc=%0d got %b exp 1", k, imem_req_ack);
            end
            tick();
        end
        dmem_req = 1'b1;
        mem_resp = SCR1_MEM_RESP_RDY_OK;
        #1;
        n_checks++;
        if (mem_req !== 1'b0 || imem_req_ack !== 1'b0 || dmem_req_ack !== 1'b0) begin
            n_fail++; $display("FAIL fill_full got req=%b i=%b d=%b exp 0/0/0", mem_req, imem_req_ack, dmem_req_ack);
        end
        n_checks++;
        if (imem_resp !== SCR1_MEM_RESP_RDY_OK) begin
            n_fail++; $display("FAIL fill_pop_resp got %0d exp 1", imem_resp);
        end
        tick();
        mem_resp = SCR1_MEM_RESP_NOTRDY; dmem_req = 1'b0;
        #1;
        n_checks++;
        if (imem_req_ack !== 1'b1 || mem_req !== 1'b1) begin
            n_fail++; $display("FAIL fill_resume got ack=%b req=%b exp 1/1", imem_req_ack, mem_req);
        end
        tick();
        idle_inputs();
        mem_resp = SCR1_MEM_RESP_RDY_OK;
        tick(); tick();
        idle_inputs();
    endtask

    task automatic test_ordering();
        do_reset();
        dmem_req = 1'b1; dmem_cmd = SCR1_MEM_CMD_WR; dmem_width = SCR1_MEM_WIDTH_HWORD;
        dmem_addr = 32'h1000; dmem_wdata = 32'hCAFE_0123; mem_req_ack = 1'b1;
        #1;
        n_checks++;
        if (mem_cmd !== SCR1_MEM_CMD_WR || mem_addr !== 32'h1000 || mem_wdata !== 32'hCAFE_0123 || mem_width !== SCR1_MEM_WIDTH_HWORD) begin
            n_fail++; $display("FAIL order_dmem_req got cmd=%0d addr=%h wd=%h w=%0d", mem_cmd, mem_addr, mem_wdata, mem_width);
        end
        tick();
        dmem_req = 1'b0; imem_req = 1'b1; imem_addr = 32'h204;
        #1;
        n_checks++;
        if (mem_addr !== 32'h204 || imem_req_ack !== 1'b1 || mem_cmd !== SCR1_MEM_CMD_RD) begin
            n_fail++; $display("FAIL order_imem_req got addr=%h ack=%b cmd=%0d exp 204/1/0", mem_addr, imem_req_ack, mem_cmd);
        end
        tick();
        imem_req = 1'b0; mem_req_ack = 1'b0; mem_resp = SCR1_MEM_RESP_RDY_ER; mem_rdata = 32'hDEAD;
        #1;
        n_checks++;
        if (dmem_resp !== SCR1_MEM_RESP_RDY_ER || imem_resp !== SCR1_MEM_RESP_NOTRDY) begin
            n_fail++; $display("FAIL order_first got i=%0d d=%0d exp 0/2", imem_resp, dmem_resp);
        end
        tick();
        mem_resp = SCR1_MEM_RESP_RDY_OK; mem_rdata = 32'h55;
        #1;
        n_checks++;
        if (imem_resp !== SCR1_MEM_RESP_RDY_OK || imem_rdata !== 32'h55 || dmem_resp !== SCR1_MEM_RESP_NOTRDY) begin
            n_fail++; $display("FAIL order_second got i=%0d rd=%h d=%0d exp 1/55/0", imem_resp, imem_rdata, dmem_resp);
        end
        tick();
        idle_inputs();
    endtask

    task automatic test_push_pop();
        do_reset();
        imem_req = 1'b1; mem_req_ack = 1'b1;
        tick();
        imem_req = 1'b0; dmem_req = 1'b1; mem_resp = SCR1_MEM_RESP_RDY_OK;
        #1;
        n_checks++;
        if (imem_resp !== SCR1_MEM_RESP_RDY_OK || dmem_req_ack !== 1'b1) begin
            n_fail++; $display("FAIL pushpop_same got iresp=%0d dack=%b exp 1/1", imem_resp, dmem_req_ack);
        end
        tick();
        dmem_req = 1'b0; imem_req = 1'b1;
        #1;
        n_checks++;
        if (dmem_resp !== SCR1_MEM_RESP_RDY_OK || imem_resp !== SCR1_MEM_RESP_NOTRDY || imem_req_ack !== 1'b1) begin
            n_fail++; $display("FAIL pushpop_next got d=%0d i=%0d iack=%b exp 1/0/1", dmem_resp, imem_resp, imem_req_ack);
        end
        tick();
        imem_req = 1'b0;
        #1;
        n_checks++;
        if (imem_resp !== SCR1_MEM_RESP_RDY_OK) begin
            n_fail++; $display("FAIL pushpop_last got %0d exp 1", imem_resp);
        end
        tick();
        idle_inputs();
    endtask

    task automatic test_mid_reset();
        do_reset();
        imem_req = 1'b1; mem_req_ack = 1'b1;
        tick(); tick();
        rst = 1'b1;
        tick();
        rst = 1'b0; imem_req = 1'b0; mem_req_ack = 1'b0; mem_resp = SCR1_MEM_RESP_RDY_OK;
        #1;
        n_checks++;
        if (imem_resp !== SCR1_MEM_RESP_NOTRDY || dmem_resp !== SCR1_MEM_RESP_NOTRDY) begin
            n_fail++; $display("FAIL midrst_stray got i=%0d d=%0d exp 0/0", imem_resp, dmem_resp);
        end
        tick();
        mem_resp = SCR1_MEM_RESP_NOTRDY; dmem_req = 1'b1; mem_req_ack = 1'b1;
        #1;
        n_checks++;
        if (dmem_req_ack !== 1'b1 || mem_req !== 1'b1) begin
            n_fail++; $display("FAIL midrst_empty got ack=%b req=%b exp 1/1", dmem_req_ack, mem_req);
        end
        tick();
        idle_inputs();
        mem_resp = SCR1_MEM_RESP_RDY_OK;
        tick();
        idle_inputs();
    endtask

    task automatic test_random();
        do_reset();
        for (int k = 0; k < 500; k++) begin
            rst         = ($urandom_range(63) == 0);
            imem_req    = 1'($urandom_range(1));
            dmem_req    = 1'($urandom_range(1));
            imem_addr   = $urandom;
            dmem_addr   = $urandom;
            dmem_wdata  = $urandom;
            dmem_cmd    = type_scr1_mem_cmd_e'(1'($urandom_range(1)));
            dmem_width  = type_scr1_mem_width_e'(2'($urandom_range(2)));
            mem_req_ack = ($urandom_range(3) != 0);
            mem_rdata   = $urandom;
            if (mq.size() > 0 && $urandom_range(2) != 0)
                mem_resp = ($urandom_range(3) == 0) ? SCR1_MEM_RESP_RDY_ER : SCR1_MEM_RESP_RDY_OK;
            else
                mem_resp = SCR1_MEM_RESP_NOTRDY;
            #1;
            model_eval();
            n_checks++;
            if (mem_req !== e_mem_req) begin
                n_fail++; $display("FAIL rnd_mem_req cyc=%0d got %b exp %b", k, mem_req, e_mem_req);
            end
            if (imem_req || dmem_req) begin
                n_checks++;
                if (imem_req_ack !== e_iack || dmem_req_ack !== e_dack) begin
                    n_fail++; $display("FAIL rnd_acks cyc=%0d got i=%b d=%b exp i=%b d=%b", k, imem_req_ack, dmem_req_ack, e_iack, e_dack);
                end
            end
            n_checks++;
            if (imem_resp !== e_iresp || dmem_resp !== e_dresp || imem_rdata !== mem_rdata || dmem_rdata !== mem_rdata) begin
                n_fail++; $display("FAIL rnd_resp cyc=%0d got i=%0d d=%0d exp i=%0d d=%0d", k, imem_resp, dmem_resp, e_iresp, e_dresp);
            end
            if (e_mem_req) begin
                n_checks++;
                if (mem_addr !== (e_sel ? dmem_addr : imem_addr)
                    || mem_cmd !== (e_sel ? dmem_cmd : SCR1_MEM_CMD_RD)
                    || mem_width !== (e_sel ? dmem_width : SCR1_MEM_WIDTH_WORD)
                    || (e_sel && mem_wdata !== dmem_wdata)) begin
                    n_fail++; $display("FAIL rnd_mux cyc=%0d got addr=%h cmd=%0d w=%0d sel_exp=%b", k, mem_addr, mem_cmd, mem_width, e_sel);
                end
            end
            tick();
        end
        rst = 1'b0;
        idle_inputs();
    endtask

    initial begin
        rst = 1'b1;
        m_lg = 1'b0;
        idle_inputs();
        @(negedge clk);
        test_reset();
        test_single_imem();
        test_conflict();
        test_back_to_back();
        test_ordering();
        test_push_pop();
        test_mid_reset();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
